alu_iterative: RTL and testbench



---
 rtl/alu_iterative.sv | 107 ++++++++++
 tb/tb_alu_iterative.sv | 104 ++++++++++
 2 files changed

// File: rtl/alu_iterative.sv
// alu_iterative: execute-stage ALU, single-cycle logic/arith/compare, bit-serial shifts
module alu_iterative #(
  parameter int DATA_WIDTH = 32,
  parameter int SHAMT_W    = $clog2(DATA_WIDTH)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            operation,
  input  logic [DATA_WIDTH-1:0] src_a,
  input  logic [DATA_WIDTH-1:0] src_b,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] result,
  output logic                  branch_taken
);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2;
  localparam logic [3:0] OP_SLL = 4'b0100, OP_SRL = 4'b0111, OP_SRA = 4'b1000;
  logic [1:0]            state_q, state_d;
  logic [DATA_WIDTH-1:0] result_q, result_d, work_q, work_d, alu_res, shifted;
  logic                  branch_q, branch_d, alu_br, is_shift;
  logic [SHAMT_W-1:0]    cnt_q, cnt_d, shamt;
  logic [3:0]            op_q, op_d;
  assign in_ready     = (state_q == IDLE) && !reset;
  assign out_valid    = state_q == DONE;
  assign result       = result_q;
  assign branch_taken = branch_q;
  assign shamt        = src_b[SHAMT_W-1:0];
  assign is_shift     = operation == OP_SLL || operation == OP_SRL || operation == OP_SRA;
  assign shifted      = op_q == OP_SLL ? work_q << 1
                      : {op_q == OP_SRA && work_q[DATA_WIDTH-1], work_q[DATA_WIDTH-1:1]};
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    case (operation)
      4'b0000: alu_res = src_a & src_b;
      4'b0001: alu_res = src_a | src_b;
      4'b0010: alu_res = src_a + src_b;
      4'b0011: alu_res = src_a - src_b;
      4'b0110: alu_res = src_a ^ src_b;
      4'b1001: alu_res = ~(src_a | src_b);
      4'b0101: alu_res = {{(DATA_WIDTH-1){1'b0}}, $signed(src_a) < $signed(src_b)};
      4'b1100: alu_res = {{(DATA_WIDTH-1){1'b0}}, src_a < src_b};
      4'b1010: begin
        alu_br  = src_a == src_b;
        alu_res = {{(DATA_WIDTH-1){1'b0}}, alu_br};
      end
      4'b1011: begin
        alu_br  = src_a != src_b;
        alu_res = {{(DATA_WIDTH-1){1'b0}}, alu_br};
      end
      OP_SLL, OP_SRL, OP_SRA: alu_res = src_a;
      default: alu_res = '0;
    endcase
  end
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    branch_d = branch_q;
    work_d   = work_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    case (state_q)
      IDLE: if (in_valid) begin
        if (is_shift && shamt != '0) begin
          work_d  = src_a;
          cnt_d   = shamt;
          op_d    = operation;
          state_d = SHIFT;
        end else begin
          result_d = alu_res;
          branch_d = alu_br;
          state_d  = DONE;
        end
      end
      SHIFT: begin
        work_d = shifted;
        cnt_d  = cnt_q - SHAMT_W'(1);
        if (cnt_q == SHAMT_W'(1)) begin
          result_d = shifted;
          branch_d = 1'b0;
          state_d  = DONE;
        end
      end
      DONE: state_d = out_ready ? IDLE : DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      result_q <= '0;
      branch_q <= 1'b0;
      work_q   <= '0;
      cnt_q    <= '0;
      op_q     <= '0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      branch_q <= branch_d;
      work_q   <= work_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
    end
  end
endmodule

// File: tb/tb_alu_iterative.sv
// tb_alu_iterative: directed vectors with hand-computed results, latency and handshake checks
module tb_alu_iterative;
  logic        clk = 1'b0, reset = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [3:0]  operation = '0;
  logic [31:0] src_a = '0, src_b = '0;
  logic        in_ready, out_valid, branch_taken;
  logic [31:0] result;
  int          n_checks = 0, n_fail = 0;
  alu_iterative #(.DATA_WIDTH(32)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .operation(operation), .src_a(src_a), .src_b(src_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .branch_taken(branch_taken)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask
  // inputs are scrambled right after accept to prove they are sampled only once
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_res,
                        input logic exp_br, input int hold);
    int lat, rdy_seen;
    check({tag, " ready_before"}, in_ready, 1);
    operation = op; src_a = a; src_b = b; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0; operation = ~op; src_a = ~a; src_b = ~b;
    lat = 1; rdy_seen = 0;
    while (!out_valid && lat < 80) begin
      if (in_ready) rdy_seen++;
      @(posedge clk); #1;
      lat++;
    end
    check({tag, " out_valid"}, out_valid, 1);
    check({tag, " latency"}, lat, exp_lat);
    check({tag, " ready_busy"}, rdy_seen, 0);
    check({tag, " result"}, result, exp_res);
    check({tag, " branch"}, branch_taken, exp_br);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, " hold_valid"}, out_valid, 1);
      check({tag, " hold_result"}, result, exp_res);
      check({tag, " hold_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, " released"}, out_valid, 0);
    check({tag, " ready_after"}, in_ready, 1);
  endtask
  initial begin
    int seen;
    repeat (3) @(posedge clk);
    #1;
    check("rst in_ready", in_ready, 0);
    check("rst out_valid", out_valid, 0);
    check("rst result", result, 0);
    check("rst branch", branch_taken, 0);
    reset = 1'b0;
    #1;
    check("post_rst in_ready", in_ready, 1);
    run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 1'b0, 0);
    run_op("sra4", 4'b1000, 32'h8000_0000, 32'h4, 5, 32'hF800_0000, 1'b0, 0);
    run_op("sra2_pos", 4'b1000, 32'h4000_0000, 32'h2, 3, 32'h1000_0000, 1'b0, 0);
    run_op("sll0", 4'b0100, 32'h1, 32'h0, 1, 32'h1, 1'b0, 0);
    run_op("sll31", 4'b0100, 32'h1, 32'd31, 32, 32'h8000_0000, 1'b0, 0);
    run_op("srl_hi", 4'b0111, 32'hFFFF_FFFF, 32'h21, 2, 32'h7FFF_FFFF, 1'b0, 0);
    run_op("and", 4'b0000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 1'b0, 0);
    run_op("or", 4'b0001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hFFF0_FFF0, 1'b0, 0);
    run_op("xor", 4'b0110, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h0FF0_0FF0, 1'b0, 0);
    run_op("nor", 4'b1001, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'h000F_000F, 1'b0, 0);
    run_op("slt", 4'b0101, 32'hFFFF_FFFF, 32'h1, 1, 32'h1, 1'b0, 0);
    run_op("sltu", 4'b1100, 32'hFFFF_FFFF, 32'h1, 1, 32'h0, 1'b0, 0);
    run_op("beq_eq", 4'b1010, 32'h5, 32'h5, 1, 32'h1, 1'b1, 0);
    run_op("bne_eq", 4'b1011, 32'h5, 32'h5, 1, 32'h0, 1'b0, 0);
    run_op("bne_ne", 4'b1011, 32'h5, 32'h6, 1, 32'h1, 1'b1, 0);
    run_op("sub_bp", 4'b0011, 32'h3, 32'h5, 1, 32'hFFFF_FFFE, 1'b0, 4);
    operation = 4'b0100; src_a = 32'h1; src_b = 32'd20; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst result", result, 0);
    check("midrst in_ready", in_ready, 0);
    reset = 1'b0;
    seen = 0;
    repeat (30) begin
      @(posedge clk); #1;
      if (out_valid) seen++;
    end
    check("midrst no_output", seen, 0);
    check("midrst result_idle", result, 0);
    run_op("add_after_rst", 4'b0010, 32'h2, 32'h2, 1, 32'h4, 1'b0, 0);
    run_op("undef_1111", 4'b1111, 32'h5, 32'h3, 1, 32'h0, 1'b0, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
